// File: rtl/imem_loader_pkg.sv
// Shared MIPS definitions: instruction kinds, opcode/funct fields, loader
// state and error codes, plus the two word-format encoders.
package imem_loader_pkg;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_ADDI = 4'd8
  } instr_kind_e;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ADDI    = 6'b001000;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } ld_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_KIND = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  function automatic logic [31:0] enc_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] enc_itype(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imem_loader_encoder.sv
// Combinational encoder: instruction kind plus register/immediate fields to a
// 32-bit MIPS word; kind_ok flags kinds the core understands.
module imem_loader_encoder
  import imem_loader_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_kind_ok
);

  // Kind decode; unknown kinds yield a zero word with kind_ok low
  always_comb begin
    o_word    = 32'h0000_0000;
    o_kind_ok = 1'b0;
    case (i_kind)
      KIND_ADD:  begin o_word = enc_rtype(i_rs, i_rt, i_rd, FUNCT_ADD); o_kind_ok = 1'b1; end
      KIND_SUB:  begin o_word = enc_rtype(i_rs, i_rt, i_rd, FUNCT_SUB); o_kind_ok = 1'b1; end
      KIND_AND:  begin o_word = enc_rtype(i_rs, i_rt, i_rd, FUNCT_AND); o_kind_ok = 1'b1; end
      KIND_OR:   begin o_word = enc_rtype(i_rs, i_rt, i_rd, FUNCT_OR);  o_kind_ok = 1'b1; end
      KIND_SLT:  begin o_word = enc_rtype(i_rs, i_rt, i_rd, FUNCT_SLT); o_kind_ok = 1'b1; end
      KIND_LW:   begin o_word = enc_itype(OP_LW,   i_rs, i_rt, i_imm); o_kind_ok = 1'b1; end
      KIND_SW:   begin o_word = enc_itype(OP_SW,   i_rs, i_rt, i_imm); o_kind_ok = 1'b1; end
      KIND_BEQ:  begin o_word = enc_itype(OP_BEQ,  i_rs, i_rt, i_imm); o_kind_ok = 1'b1; end
      KIND_ADDI: begin o_word = enc_itype(OP_ADDI, i_rs, i_rt, i_imm); o_kind_ok = 1'b1; end
      default:   begin o_word = 32'h0000_0000; o_kind_ok = 1'b0; end
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: accepts one instruction per handshake, encodes it and writes
// consecutive instruction-memory words, then releases the core via cpu_run.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_e         r_state;
  ld_state_e         w_next_state;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [1:0]        r_err_code;
  logic [ADDR_W:0]   r_load_count;

  logic [31:0]       w_word;
  logic              w_kind_ok;
  logic              w_accept;
  logic              w_restart;
  logic              w_at_last_slot;

  imem_loader_encoder u_encoder (
    .i_kind    (in_kind),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_kind_ok (w_kind_ok)
  );

  assign w_accept       = in_valid & (r_state == ST_LOAD);
  assign w_restart      = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR));
  assign w_at_last_slot = (r_load_count == LAST_SLOT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; a write into the last slot without in_last overflows
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_next_state = ST_LOAD;
        else       w_next_state = r_state;
      end
      ST_LOAD: begin
        if (!w_accept)          w_next_state = ST_LOAD;
        else if (!w_kind_ok)    w_next_state = ST_ERR;
        else if (in_last)       w_next_state = ST_DRAIN;
        else if (w_at_last_slot) w_next_state = ST_ERR;
        else                    w_next_state = ST_LOAD;
      end
      ST_DRAIN: w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    cpu_run  = 1'b0;
    err      = 1'b0;
    case (r_state)
      ST_LOAD: in_ready = 1'b1;
      ST_DONE: cpu_run  = 1'b1;
      ST_ERR:  err      = 1'b1;
      default: begin in_ready = 1'b0; cpu_run = 1'b0; err = 1'b0; end
    endcase
  end

  // Write port, word counter and error code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'h0000_0000;
      r_err_code   <= ERR_NONE;
      r_load_count <= '0;
    end else begin
      r_mem_we <= w_accept & w_kind_ok;
      if (w_accept & w_kind_ok) begin
        r_mem_addr  <= r_load_count[ADDR_W-1:0];
        r_mem_wdata <= w_word;
      end
      if (w_restart) begin
        r_load_count <= '0;
        r_err_code   <= ERR_NONE;
      end else if (w_accept) begin
        if (!w_kind_ok) begin
          r_err_code <= ERR_BAD_KIND;
        end else begin
          r_load_count <= r_load_count + CNT_ONE;
          if (w_at_last_slot & ~in_last) r_err_code <= ERR_OVERFLOW;
        end
      end
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign err_code   = r_err_code;
  assign load_count = r_load_count;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader writing MIPS instruction words into instruction memory ahead of the single-cycle core. Accepts one instruction per handshake as an operation kind plus register/immediate fields, encodes it into the 32-bit word format the core's controller decodes (opcode/funct), and writes it to consecutive word addresses. On the last instruction it releases the core via `cpu_run`. Sits between the host/testbench program source and the instruction memory write port.

## Interface
- `ADDR_W`, 6, word-address width; capacity DEPTH = 2**ADDR_W words
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a new load; honoured only in IDLE, DONE, ERR
- `in_valid`  in  1  instruction beat valid
- `in_ready`  out  1  loader accepts beat; high exactly in LOAD
- `in_kind`  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI; 9–15 invalid
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields (`in_rd` ignored for I-type)
- `in_imm`  in  16  immediate (ignored for R-type)
- `in_last`  in  1  final instruction of program
- `mem_we`  out  1  instruction memory write strobe
- `mem_addr`  out  ADDR_W  word address
- `mem_wdata`  out  32  encoded instruction
- `cpu_run`  out  1  core may fetch; high only in DONE
- `err`  out  1  sticky error, high only in ERR
- `err_code`  out  2  0 none, 1 BAD_KIND, 2 OVERFLOW
- `load_count`  out  ADDR_W+1  words written this load

## Operation
- Reset: state IDLE; all outputs 0.
- States: IDLE, LOAD, DRAIN, DONE, ERR.
- IDLE/DONE/ERR + `start` → LOAD; clears `load_count`, `err`, `err_code`. In LOAD/DRAIN `start` is ignored.
- Beat accepted on edge where `in_valid & in_ready`.
- Valid kind accepted: next cycle `mem_we`=1, `mem_addr`=`load_count` (low ADDR_W bits), `mem_wdata`=encoding; `load_count` increments.
- Encoding: R-type {6'b000000, rs, rt, rd, 5'b00000, funct}, funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010. I-type {op, rs, rt, imm}, op LW 100011, SW 101011, BEQ 000100, ADDI 001000.
- Accepted with `in_last`=1 → DRAIN (write occurs), then DONE next edge.
- Invalid kind accepted: no write, no increment; → ERR, `err_code`=1. `in_last` on that beat ignored.
- Full: beat accepted at `load_count`=DEPTH-1 with `in_last`=0 → written, then ERR, `err_code`=2. Beat at DEPTH-1 with `in_last`=1 is legal → DRAIN.
- ERR holds `in_ready`=0, `cpu_run`=0 until `start`.
- Reset mid-load: immediate return to IDLE, `mem_we` drops asynchronously; partial memory contents undefined to the core (`cpu_run`=0).

## Timing
- Throughput one instruction per cycle while `in_valid` held.
- Latency: accept edge k → `mem_we` high cycle k..k+1 (registered outputs).
- Last accept edge k → DRAIN after k, DONE after k+1; `cpu_run` high from k+1, strictly after final write commits.
- `mem_we` never high in IDLE, DONE, ERR except the write issued on the entry edge into DRAIN/ERR(overflow).
- `in_ready` and all outputs are functions of registered state only; no input-to-output combinational paths.
- `in_valid` while `in_ready`=0 is ignored; no beat buffering.

## Structure
- `mips_pkg`: instr-kind enum, opcode and funct constants (shared with controller), loader state enum, err_code constants.
- Sub-module `instr_encoder`: combinational kind+fields → {word, kind_ok}; loader wraps it with FSM, counter and output registers.

## Test plan
- Single ADD rs=1 rt=2 rd=3, `in_last`=1 → one write addr 0 data 0x00221820; `cpu_run` rises one cycle after `mem_we`; `load_count`=1.
- Back-to-back LW rs=0 rt=8 imm=4, SW rs=0 rt=7 imm=0x54, BEQ rs=4 rt=5 imm=0xFFFF, ADDI rs=0 rt=2 imm=5 (last) → addrs 0..3 data 0x8C080004, 0xAC070054, 0x1085FFFF, 0x20020005 on consecutive cycles.
- Kind=12 as second beat → only addr 0 written; `err`=1, `err_code`=1, `load_count`=1, `in_ready`=0; `start` → LOAD, `err`=0, `load_count`=0.
- ADDR_W=2: five beats none last → four writes addrs 0..3, then `err_code`=2, fifth beat not accepted; variant with fourth beat last → DONE, no error.
- Reset asserted mid-stream after 2 writes → outputs 0 asynchronously, state IDLE; `start` in LOAD/DRAIN has no effect.
- `in_valid` held high with gaps via `in_ready`/`start` timing → no beat accepted while `in_ready`=0, no duplicate writes.
